// File: rtl/vga_scanout.sv
// 640x480@60 Hz VGA scan-out for frame_cell: raster read addressing, sync generation,
// and a flag pipeline that lines colour and sync up behind frame_cell's read latency.
module vga_scanout #(
  parameter int CLK_DIV      = 4,
  parameter int H_VISIBLE    = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int READ_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] read_frame_width,
  output logic [8:0] read_frame_height,
  input  logic [2:0] read_data,
  output logic       vga_red,
  output logic       vga_green,
  output logic       vga_blue,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic       frame_start,
  output logic       in_vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  // Bit positions inside the flag word carried down the alignment pipeline.
  localparam int F_VIS = 0;
  localparam int F_HS  = 1;
  localparam int F_VS  = 2;
  localparam int F_VB  = 3;
  localparam int F_FS  = 4;

  logic [DIV_W-1:0] div_count;
  logic             pix_tick;
  logic [9:0]       h_count;
  logic [9:0]       v_count;
  logic             frame_wrap_q;

  logic             vis;
  logic             hs_raw;
  logic             vs_raw;
  logic             vb_raw;
  logic [4:0]       raw_flags;
  logic [4:0]       flag_pipe [READ_LATENCY];
  logic [4:0]       delayed;

  assign pix_tick = (div_count == DIV_LAST);

  // NOTE: every clocked register uses non-blocking assignment so all state
  // updates see the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_count <= '0;
    end else if (pix_tick) begin
      div_count <= '0;
    end else begin
      div_count <= div_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_tick) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  // High for the one clk that follows the edge entering (0,0); never set by reset itself,
  // so the first pulse only appears once a whole frame has been scanned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_wrap_q <= 1'b0;
    end else begin
      frame_wrap_q <= pix_tick && (h_count == H_LAST) && (v_count == V_LAST);
    end
  end

  assign vis    = (h_count < H_VIS) && (v_count < V_VIS);
  assign hs_raw = (h_count >= H_SYNC_START) && (h_count < H_SYNC_END);
  assign vs_raw = (v_count >= V_SYNC_START) && (v_count < V_SYNC_END);
  assign vb_raw = (v_count >= V_VIS);

  // Address is parked at (0,0) outside the visible window so it never leaves the frame.
  assign read_frame_width  = vis ? h_count      : '0;
  assign read_frame_height = vis ? v_count[8:0] : '0;

  always_comb begin
    raw_flags        = '0;
    raw_flags[F_VIS] = vis;
    raw_flags[F_HS]  = hs_raw;
    raw_flags[F_VS]  = vs_raw;
    raw_flags[F_VB]  = vb_raw;
    raw_flags[F_FS]  = frame_wrap_q;
  end

  // NOTE: the alignment pipeline is an array but is still reset element by element,
  // so no stale sync or visibility flag can reach the pins after a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        flag_pipe[i] <= '0;
      end
    end else begin
      flag_pipe[0] <= raw_flags;
      for (int i = 1; i < READ_LATENCY; i++) begin
        flag_pipe[i] <= flag_pipe[i-1];
      end
    end
  end

  assign delayed = flag_pipe[READ_LATENCY-1];

  // Output stage: read_data is valid now for the flags that left the counters
  // READ_LATENCY clks ago; colour is forced dark outside the visible window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_red     <= 1'b0;
      vga_green   <= 1'b0;
      vga_blue    <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
      in_vblank   <= 1'b0;
    end else begin
      vga_red     <= delayed[F_VIS] & read_data[2];
      vga_green   <= delayed[F_VIS] & read_data[1];
      vga_blue    <= delayed[F_VIS] & read_data[0];
      vga_hsync   <= ~delayed[F_HS];
      vga_vsync   <= ~delayed[F_VS];
      frame_start <= delayed[F_FS];
      in_vblank   <= delayed[F_VB];
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a shrunken raster: a 1-cycle frame_cell model,
// queued expected pin values, and edge-to-edge timing measurements.
module tb_vga_scanout;

  localparam int D   = 3;
  localparam int HV  = 16;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HBP = 2;
  localparam int VV  = 8;
  localparam int VFP = 1;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HV + HFP + HS + HBP;
  localparam int VT  = VV + VFP + VS + VBP;
  localparam int F   = D * HT * VT;

  localparam logic [6:0] RESET_PINS = 7'b000_1100;

  typedef struct {
    int         due;
    logic [6:0] pins;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] read_frame_width;
  logic [8:0] read_frame_height;
  logic [2:0] read_data = 3'b000;
  logic       vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start, in_vblank;

  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  logic mode = 1'b1;

  int   m_div = 0, m_h = 0, m_v = 0;
  logic m_fs = 1'b0;

  exp_t q[$];
  int   rel_edge = 0;
  int   last_hfall = -1, last_vfall = -1, last_fs = -1, vb_rise = -1;
  int   fs_count = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0, prev_vb = 1'b0;

  vga_scanout #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .READ_LATENCY(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .read_frame_width(read_frame_width),
    .read_frame_height(read_frame_height),
    .read_data(read_data),
    .vga_red(vga_red),
    .vga_green(vga_green),
    .vga_blue(vga_blue),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .frame_start(frame_start),
    .in_vblank(in_vblank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // frame_cell model: one-cycle synchronous read of either a pattern or solid white.
  always @(posedge clk) begin
    read_data <= mode ? 3'b111 : 3'((int'(read_frame_width) + int'(read_frame_height)) % 8);
  end

  // Reference raster position, advanced once per CLK_DIV clks.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div <= 0;
      m_h   <= 0;
      m_v   <= 0;
      m_fs  <= 1'b0;
    end else begin
      m_fs <= 1'b0;
      if (m_div == D - 1) begin
        m_div <= 0;
        if (m_h == HT - 1) begin
          m_h <= 0;
          if (m_v == VT - 1) begin
            m_v  <= 0;
            m_fs <= 1'b1;
          end else begin
            m_v <= m_v + 1;
          end
        end else begin
          m_h <= m_h + 1;
        end
      end else begin
        m_div <= m_div + 1;
      end
    end
  end

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic model_vis();
    return (m_h < HV) && (m_v < VV);
  endfunction

  function automatic exp_t model_out(input int due);
    exp_t       e;
    logic [2:0] rgb;
    rgb = 3'd0;
    if (model_vis()) rgb = mode ? 3'd7 : 3'((m_h + m_v) % 8);
    e.due  = due;
    e.pins = {rgb,
              !((m_h >= HV + HFP) && (m_h < HV + HFP + HS)),
              !((m_v >= VV + VFP) && (m_v < VV + VFP + VS)),
              (m_v >= VV),
              m_fs};
    return e;
  endfunction

  function automatic logic [6:0] dut_pins();
    return {vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, in_vblank, frame_start};
  endfunction

  // Scoreboard and timing monitor, sampled mid-cycle.
  initial begin : monitor
    exp_t e;
    int   k;
    forever begin
      @(negedge clk);
      k = edge_cnt;
      if (rst) begin
        check("rst_pins", dut_pins(), RESET_PINS);
        q.delete();
        e.due = k + 1; e.pins = RESET_PINS; q.push_back(e);
        e.due = k + 2; e.pins = RESET_PINS; q.push_back(e);
        rel_edge   = k + 1;
        last_hfall = -1;
        last_vfall = -1;
        last_fs    = -1;
        vb_rise    = -1;
        fs_count   = 0;
      end else begin
        if (q.size() > 0 && q[0].due == k) begin
          e = q.pop_front();
          check("pins", dut_pins(), e.pins);
        end
        q.push_back(model_out(k + 2));
        check("addr_w", read_frame_width, model_vis() ? m_h : 0);
        check("addr_h", read_frame_height, model_vis() ? m_v : 0);

        if (prev_hs && !vga_hsync) begin
          if (last_hfall >= 0) check("hs_period", k - last_hfall, HT * D);
          else                 check("hs_first", k - rel_edge, (HV + HFP) * D + 2);
          last_hfall = k;
        end
        if (!prev_hs && vga_hsync && last_hfall >= 0) check("hs_width", k - last_hfall, HS * D);

        if (prev_vs && !vga_vsync) begin
          if (last_vfall >= 0) check("vs_period", k - last_vfall, F);
          last_vfall = k;
        end
        if (!prev_vs && vga_vsync && last_vfall >= 0) check("vs_width", k - last_vfall, VS * HT * D);

        if (!prev_fs && frame_start) begin
          if (last_fs >= 0) check("fs_period", k - last_fs, F);
          else              check("fs_first", k - rel_edge, F + 2);
          last_fs = k;
          fs_count++;
        end
        if (prev_fs && !frame_start) check("fs_width", k - last_fs, 1);

        if (!prev_vb && in_vblank) vb_rise = k;
        if (prev_vb && !in_vblank && vb_rise >= 0) check("vblank_len", k - vb_rise, (VT - VV) * HT * D);
      end
      prev_hs = vga_hsync;
      prev_vs = vga_vsync;
      prev_fs = frame_start;
      prev_vb = in_vblank;
    end
  end

  initial begin : stimulus
    logic found;
    rst  = 1'b1;
    mode = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rel_addr", {read_frame_height, read_frame_width}, 0);
    check("rel_rgb0", {vga_red, vga_green, vga_blue}, 0);
    @(negedge clk);
    check("rel_rgb1", {vga_red, vga_green, vga_blue}, 0);
    @(negedge clk);
    check("rel_rgb2", {vga_red, vga_green, vga_blue}, 7);

    // First frame runs on solid white; switch to the pattern inside vertical blanking.
    found = 1'b0;
    for (int i = 0; i < 2 * F && !found; i++) begin
      @(negedge clk);
      found = (m_v == VV + 1);
    end
    check("wait_vblank", found, 1);
    mode = 1'b0;

    repeat (2 * F) @(posedge clk);

    found = 1'b0;
    for (int i = 0; i < 2 * F && !found; i++) begin
      @(negedge clk);
      found = (m_v == 5) && (m_h == 10);
    end
    check("wait_midframe", found, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    repeat (2 * F + 20) @(posedge clk);
    @(negedge clk);
    check("fs_count", fs_count, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
- Display-side consumer of frame_cell. Generates 640x480@60 Hz VGA timing from the system clock.
- Drives frame_cell's read address port (read_frame_width / read_frame_height) in raster order and consumes its 3-bit read_data.
- Emits pixel-aligned 1-bit R/G/B plus active-low hsync/vsync to the board VGA pins.
- Compensates for frame_cell's synchronous read latency so that colour and sync leave the block phase-aligned.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); legal range >= 2
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BP, 33, vertical back porch, lines
- READ_LATENCY, 1, clk cycles from address to valid read_data in frame_cell

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- read_frame_width  output  10  frame_cell read column
- read_frame_height  output  9  frame_cell read row
- read_data  input  3  pixel from frame_cell: bit2 = R, bit1 = G, bit0 = B
- vga_red  output  1  red
- vga_green  output  1  green
- vga_blue  output  1  blue
- vga_hsync  output  1  horizontal sync, active low
- vga_vsync  output  1  vertical sync, active low
- frame_start  output  1  one-clk pulse at start of each frame
- in_vblank  output  1  high while v_count >= V_VISIBLE

Behaviour:
- Reset (async, rst high):
  - div_count, h_count and v_count are 0.
  - All delay-pipeline stages are cleared.
  - Outputs: vga_red/green/blue = 0, vga_hsync = 1, vga_vsync = 1, frame_start = 0, in_vblank = 0.
- Pixel tick (pix_tick):
  - div_count counts 0..CLK_DIV-1 and wraps.
  - pix_tick is asserted on the clk where div_count == CLK_DIV-1.
- Counters (advance only on pix_tick):
  - H_TOTAL = 800, V_TOTAL = 525, derived as the sums of the timing parameters.
  - h_count runs 0..H_TOTAL-1.
  - When h_count wraps to 0, v_count increments; v_count wraps 524 -> 0.
- Read address (combinational from the counters):
  - When visible (h_count < H_VISIBLE and v_count < V_VISIBLE): read_frame_width = h_count, read_frame_height = v_count.
  - Otherwise both are driven to 0; the address never leaves the 640x480 range.
- Raw control flags (combinational):
  - vis = visible
  - hs_raw = H_VISIBLE+H_FP <= h_count < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751
  - vs_raw = V_VISIBLE+V_FP <= v_count < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491
- Alignment pipeline:
  - vis, hs_raw and vs_raw pass through a READ_LATENCY-stage shift register, clocked every clk.
  - The output registers then capture on every clk:
    - vga_red/green/blue = delayed_vis ? read_data bits : 0
    - vga_hsync = ~delayed_hs
    - vga_vsync = ~delayed_vs
  - Total latency from a counter change to the matching pin change is READ_LATENCY+1 clk.
  - Each pixel is held for CLK_DIV clks.
- Blanking: RGB is forced to 0 whenever delayed_vis = 0, regardless of read_data.
- frame_start:
  - Registered pulse, exactly 1 clk wide.
  - Asserted READ_LATENCY+1 clk after the counter edge that enters (h,v) = (0,0).
  - Not asserted on the first (0,0) after reset; the first pulse comes after one full frame.
- in_vblank: registered, same READ_LATENCY+1 alignment as the sync outputs.
- No stall or back-pressure: frame_cell is dual-ported and always serves the read address. Simultaneous writes to the same address are frame_cell's concern; this block reads whatever it returns.
- Reset mid-operation: all counters return to 0 immediately and sync outputs deassert. After release, timing restarts from pixel (0,0) with a fresh CLK_DIV phase, so the first pix_tick comes CLK_DIV clks after release.
- Widths: h_count is 10 bits, v_count is 10 bits internally; read_frame_height uses the low 9 bits of v_count, which is valid because the address is < 480.

Test Plan:
- Reset check: hold rst 3 clk, then release with read_data = 3'b111. Required: RGB = 0 and hsync = vsync = 1 throughout reset; address is (0,0) after release; first RGB = 3'b111 appears READ_LATENCY+1 = 2 clk after release.
- Address raster: model frame_cell as a 1-cycle RAM holding (w+h) mod 8. Scan one full frame and compare every visible RGB sample against the model. Zero mismatches; address = (0,0) throughout every blanking interval.
- Horizontal timing: measure vga_hsync. Low for 384 clk (96x4), falling edges 3200 clk apart, first falling edge 2624 clk (656x4) after line start plus 2 clk latency.
- Vertical timing: measure vga_vsync. Low for 6400 clk (2 lines), frame period 1,680,000 clk, frame_start pulses exactly once per frame and is 1 clk wide.
- Blanking force: hold read_data = 3'b111 constantly. RGB = 0 for h_count 640..799 and v_count 480..524; in_vblank = 1 for exactly 45 lines per frame.
- Mid-frame reset: assert rst at line 200, pixel 300 for 1 clk. Outputs return to reset values within the same clk; after release the next frame_start arrives 1,680,000 clk later.
